aes_xts_tweak_sequencer: RTL

//  Upstream/downstream wrapper stage around the 14-round AES-256 encrypt core.
//  - Accepts plaintext blocks and the per-sector encrypted tweak T0.
//  - Pre-XORs each block with T, then issues a one-cycle write to the core.
//  - Captures the core result and post-XORs it with the same T.
//  - Advances T by multiplication by alpha in GF(2^128).
//  - Presents the ciphertext on a valid/ready output.

---
 rtl/aes_xts_pkg.sv | 25 ++
 rtl/aes_xts_gf_mul_alpha.sv | 13 +
 rtl/aes_xts_tweak_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/aes_xts_pkg.sv
// Shared types and helpers for the AES-XTS tweak sequencer: FSM states,
// block width, GF(2^128) feedback constant and the multiply-by-alpha step.
package aes_xts_pkg;

  localparam int         AES_BLOCK_W = 128;
  localparam logic [7:0] XTS_GF_POLY = 8'h87;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } xts_state_e;

  // Shift left by one; if the top bit falls out, fold it back via the polynomial.
  function automatic logic [AES_BLOCK_W-1:0] xts_mul_alpha(
    input logic [AES_BLOCK_W-1:0] t,
    input logic [7:0]             poly = XTS_GF_POLY
  );
    logic [AES_BLOCK_W-1:0] fb;
    fb = {{(AES_BLOCK_W-8){1'b0}}, poly} & {AES_BLOCK_W{t[AES_BLOCK_W-1]}};
    return {t[AES_BLOCK_W-2:0], 1'b0} ^ fb;
  endfunction

endpackage

// File: rtl/aes_xts_gf_mul_alpha.sv
// Combinational tweak advance: T * alpha in GF(2^128).
module aes_xts_gf_mul_alpha
  import aes_xts_pkg::*;
#(
  parameter logic [7:0] GF_POLY = XTS_GF_POLY
) (
  input  logic [AES_BLOCK_W-1:0] tweak_i,
  output logic [AES_BLOCK_W-1:0] tweak_o
);

  assign tweak_o = xts_mul_alpha(tweak_i, GF_POLY);

endmodule

// File: rtl/aes_xts_tweak_sequencer.sv
// XTS wrapper around an AES encrypt core: pre/post-XOR with the tweak, one
// block in flight, tweak advanced by alpha per block. Optional sector block
// counting is enabled with `define AES_XTS_BLOCK_COUNT_EN.
module aes_xts_tweak_sequencer
  import aes_xts_pkg::*;
#(
  parameter int         BLOCK_W = AES_BLOCK_W,
  parameter logic [7:0] GF_POLY = XTS_GF_POLY
`ifdef AES_XTS_BLOCK_COUNT_EN
  , parameter int       MAX_BLOCKS = 256
`endif
) (
  input  logic               inClk,
  input  logic               inRst,
  input  logic               inTweakWr,
  input  logic [BLOCK_W-1:0] inTweak,
  input  logic               inDataValid,
  input  logic [BLOCK_W-1:0] inData,
  output logic               outDataReady,
  output logic               outCoreWr,
  output logic [BLOCK_W-1:0] outCoreData,
  input  logic               inCoreBusy,
  input  logic               inCoreDone,
  input  logic [BLOCK_W-1:0] inCoreData,
  output logic               outResultValid,
  output logic [BLOCK_W-1:0] outResult,
  input  logic               inResultReady,
  output logic               outBusy
`ifdef AES_XTS_BLOCK_COUNT_EN
  , output logic [$clog2(MAX_BLOCKS):0] outBlockCnt
  , output logic                        outSectorFull
`endif
);

  xts_state_e         state_q, state_d;
  logic [BLOCK_W-1:0] tweak_q, tweak_d;
  logic [BLOCK_W-1:0] tweak_alpha;
  logic               pend_q, pend_d;
  logic [BLOCK_W-1:0] pend_tweak_q, pend_tweak_d;
  logic               core_wr_q, core_wr_d;
  logic [BLOCK_W-1:0] core_data_q, core_data_d;
  logic               res_valid_q, res_valid_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic               sector_full;
  logic               accept;

`ifdef AES_XTS_BLOCK_COUNT_EN
  localparam int CNT_W = $clog2(MAX_BLOCKS) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sector_full   = (cnt_q == CNT_W'(MAX_BLOCKS));
  assign outBlockCnt   = cnt_q;
  assign outSectorFull = sector_full;
`else
  assign sector_full = 1'b0;
`endif

  aes_xts_gf_mul_alpha #(
    .GF_POLY (GF_POLY)
  ) u_mul_alpha (
    .tweak_i (tweak_q),
    .tweak_o (tweak_alpha)
  );

  assign outDataReady   = (state_q == READY) & ~inCoreBusy & ~sector_full;
  assign accept         = outDataReady & inDataValid;
  assign outBusy        = (state_q == WAIT) | (state_q == OUT);
  assign outCoreWr      = core_wr_q;
  assign outCoreData    = core_data_q;
  assign outResultValid = res_valid_q;
  assign outResult      = res_q;

  always_comb begin
    state_d      = state_q;
    tweak_d      = tweak_q;
    pend_d       = pend_q;
    pend_tweak_d = pend_tweak_q;
    core_wr_d    = 1'b0;
    core_data_d  = core_data_q;
    res_valid_d  = res_valid_q;
    res_d        = res_q;
`ifdef AES_XTS_BLOCK_COUNT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (inTweakWr) begin
          tweak_d = inTweak;
          state_d = READY;
`ifdef AES_XTS_BLOCK_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      READY: begin
        if (accept) begin
          core_wr_d   = 1'b1;
          core_data_d = inData ^ tweak_q;
          state_d     = WAIT;
          // A T0 arriving with the block waits until this block's result has left.
          if (inTweakWr) begin
            pend_d       = 1'b1;
            pend_tweak_d = inTweak;
          end
        end else if (inTweakWr) begin
          tweak_d = inTweak;
`ifdef AES_XTS_BLOCK_COUNT_EN
          cnt_d   = '0;
`endif
        end
      end
      WAIT: begin
        if (inCoreDone) begin
          res_d       = inCoreData ^ tweak_q;
          res_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        if (inResultReady) begin
          res_valid_d = 1'b0;
          state_d     = READY;
          if (pend_q) begin
            tweak_d = pend_tweak_q;
            pend_d  = 1'b0;
`ifdef AES_XTS_BLOCK_COUNT_EN
            cnt_d   = '0;
`endif
          end else begin
            tweak_d = tweak_alpha;
`ifdef AES_XTS_BLOCK_COUNT_EN
            cnt_d   = cnt_q + 1'b1;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q      <= IDLE;
      tweak_q      <= '0;
      pend_q       <= 1'b0;
      pend_tweak_q <= '0;
      core_wr_q    <= 1'b0;
      core_data_q  <= '0;
      res_valid_q  <= 1'b0;
      res_q        <= '0;
`ifdef AES_XTS_BLOCK_COUNT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tweak_q      <= tweak_d;
      pend_q       <= pend_d;
      pend_tweak_q <= pend_tweak_d;
      core_wr_q    <= core_wr_d;
      core_data_q  <= core_data_d;
      res_valid_q  <= res_valid_d;
      res_q        <= res_d;
`ifdef AES_XTS_BLOCK_COUNT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule
